// File: rtl/ps2_scan_controller_if.sv
// Key-event handshake between the PS/2 receiver (master) and its consumer (slave).
interface ps2_scan_controller_if;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_break;
    logic       event_extended;

    modport master (
        output event_valid,
        output event_code,
        output event_break,
        output event_extended,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_code,
        input  event_break,
        input  event_extended,
        output event_ready
    );
endinterface

// File: rtl/ps2_scan_controller.sv
// PS/2 keyboard receiver: sync/filter, 11-bit framing, E0/F0 prefix folding, event FIFO.
// Define PS2_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES without a bit strobe.
module ps2_scan_controller #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 4
`ifdef PS2_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    ps2_scan_controller_if.master        evt,
    output logic                         overflow,
    output logic                         frame_error
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] r_clkSync;
    logic [SYNC_STAGES-1:0] r_dataSync;
    logic [1:0]             r_filt;
    logic [FILT_W-1:0]      r_filtCnt [2];
    logic                   r_clkPrev;
    logic [1:0]             w_syncOut;
    logic                   w_strobe;
    logic                   w_dataBit;

    state_t                 r_state;
    logic [2:0]             r_bitCnt;
    logic [7:0]             r_shift;
    logic                   r_parity;
    logic                   r_byteValid;
    logic                   r_frameError;
    logic                   r_brk;
    logic                   r_ext;

    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [PTR_W:0]         r_count;
    logic                   r_overflow;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_write;

`ifdef PS2_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0]      r_wdog;
`endif

    // Index 0 carries the keyboard clock, index 1 the keyboard data.
    assign w_syncOut = {r_dataSync[SYNC_STAGES-1], r_clkSync[SYNC_STAGES-1]};
    assign w_strobe  = r_clkPrev & ~r_filt[0];
    assign w_dataBit = r_filt[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clkSync  <= '1;
            r_dataSync <= '1;
        end else begin
            r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], ps2_clk};
            r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // A line only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_filt       <= 2'b11;
            r_filtCnt[0] <= '0;
            r_filtCnt[1] <= '0;
            r_clkPrev    <= 1'b1;
        end else begin
            r_clkPrev <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (w_syncOut[i] == r_filt[i]) begin
                    r_filtCnt[i] <= '0;
                end else if (r_filtCnt[i] == FILT_W'(FILTER_LEN - 1)) begin
                    r_filt[i]    <= w_syncOut[i];
                    r_filtCnt[i] <= '0;
                end else begin
                    r_filtCnt[i] <= r_filtCnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_byteValid  <= 1'b0;
            r_frameError <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            r_wdog       <= '0;
`endif
        end else begin
            r_byteValid  <= 1'b0;
            r_frameError <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            if (w_strobe || r_state == IDLE) r_wdog <= '0;
            else                             r_wdog <= r_wdog + 1'b1;
`endif
            case (r_state)
                IDLE: begin
                    if (w_strobe && !w_dataBit) begin
                        r_state  <= DATA;
                        r_bitCnt <= '0;
                    end
                end
                DATA: begin
                    if (w_strobe) begin
                        r_shift  <= {w_dataBit, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == 3'd7) r_state <= PARITY;
                    end
                end
                PARITY: begin
                    if (w_strobe) begin
                        r_parity <= w_dataBit;
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    if (w_strobe) begin
                        if (w_dataBit && (^{r_shift, r_parity})) r_byteValid  <= 1'b1;
                        else                                     r_frameError <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef PS2_TIMEOUT_EN
            if (r_state != IDLE && r_wdog == WDOG_W'(TIMEOUT_CYCLES)) begin
                r_state      <= IDLE;
                r_frameError <= 1'b1;
            end
`endif
        end
    end

    // Prefix flags; a discarded frame of any kind drops pending prefixes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_frameError) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_byteValid) begin
            case (r_shift)
                8'hE0:   r_ext <= 1'b1;
                8'hF0:   r_brk <= 1'b1;
                default: begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            endcase
        end
    end

    assign w_push  = r_byteValid && (r_shift != 8'hE0) && (r_shift != 8'hF0);
    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop   = (r_count != '0) && evt.event_ready;
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wrPtr] <= {r_shift, r_brk, r_ext};
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt.event_valid    = (r_count != '0);
    assign evt.event_code     = r_mem[r_rdPtr][9:2];
    assign evt.event_break    = r_mem[r_rdPtr][1];
    assign evt.event_extended = r_mem[r_rdPtr][0];
    assign overflow           = r_overflow;
    assign frame_error        = r_frameError;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Directed self-checking bench for ps2_scan_controller (default build and PS2_TIMEOUT_EN).
module tb_ps2_scan_controller;

    logic clock = 1'b0;
    logic reset;
    logic ps2_clk;
    logic ps2_data;
    logic overflow;
    logic frame_error;

    int nCompared    = 0;
    int nMismatched  = 0;
    int errPulses    = 0;
    int errBefore;
    logic [9:0] gotQ [$];

    ps2_scan_controller_if evIf ();

    ps2_scan_controller #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .FIFO_DEPTH(4)
`ifdef PS2_TIMEOUT_EN
        , .TIMEOUT_CYCLES(1000)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .evt(evIf),
        .overflow(overflow),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Capture every accepted event and every cycle of frame_error.
    always @(negedge clock) begin
        if (!reset && evIf.event_valid && evIf.event_ready)
            gotQ.push_back({evIf.event_code, evIf.event_break, evIf.event_extended});
        if (frame_error) errPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sendBit(input logic b);
        ps2_data = b;
        waitCycles(20);
        ps2_clk = 1'b0;
        waitCycles(40);
        ps2_clk = 1'b1;
        waitCycles(20);
    endtask

    // One 11-bit frame; checkLat measures event_valid around the stop strobe.
    // 2 sync + 4 filter cycles put the strobe 6 edges after the falling edge,
    // so valid must still be low after edge 7 and high after edge 8.
    task automatic applyStimulus(input logic [7:0] code, input logic badParity, input logic checkLat);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(code[i]);
        sendBit((~^code) ^ badParity);
        if (checkLat) begin
            ps2_data = 1'b1;
            waitCycles(20);
            ps2_clk = 1'b0;
            waitCycles(7);
            checkOutput("latency_early", evIf.event_valid, 0);
            waitCycles(1);
            checkOutput("latency_rise", evIf.event_valid, 1);
            waitCycles(32);
            ps2_clk = 1'b1;
            waitCycles(20);
        end else begin
            sendBit(1'b1);
        end
        waitCycles(10);
    endtask

    task automatic checkEvent(input string tag, input logic [7:0] code, input logic brk, input logic ext);
        logic [9:0] ev;
        checkOutput({tag, "_count"}, gotQ.size(), 1);
        if (gotQ.size() > 0) begin
            ev = gotQ.pop_front();
            checkOutput({tag, "_event"}, ev, {code, brk, ext});
        end
        gotQ.delete();
    endtask

    initial begin
        logic [7:0] ovCodes [5];
        ovCodes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

        reset             = 1'b1;
        ps2_clk           = 1'b1;
        ps2_data          = 1'b1;
        evIf.event_ready  = 1'b0;
        waitCycles(5);
        reset = 1'b0;
        waitCycles(2);

        checkOutput("rst_valid", evIf.event_valid, 0);
        checkOutput("rst_code", evIf.event_code, 0);
        checkOutput("rst_break", evIf.event_break, 0);
        checkOutput("rst_ext", evIf.event_extended, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_frame_error", frame_error, 0);

        evIf.event_ready = 1'b1;
        applyStimulus(8'h1C, 1'b0, 1'b1);
        checkEvent("make_1c", 8'h1C, 1'b0, 1'b0);

        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkEvent("break_1c", 8'h1C, 1'b1, 1'b0);

        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        checkEvent("ext_break_75", 8'h75, 1'b1, 1'b1);

        errBefore = errPulses;
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkOutput("parity_err_pulses", errPulses - errBefore, 1);
        checkOutput("parity_no_event", gotQ.size(), 0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkEvent("after_err", 8'h1C, 1'b1, 1'b0);

        // Data held low so a leaked strobe would start a bogus frame.
        errBefore = errPulses;
        ps2_data = 1'b0;
        waitCycles(5);
        ps2_clk = 1'b0;
        waitCycles(2);
        ps2_clk = 1'b1;
        waitCycles(20);
        ps2_data = 1'b1;
        waitCycles(5);
        checkOutput("glitch_no_event", gotQ.size(), 0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkEvent("after_glitch", 8'h1C, 1'b0, 1'b0);
        checkOutput("glitch_no_err", errPulses - errBefore, 0);

        evIf.event_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(ovCodes[i], 1'b0, 1'b0);
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_valid", evIf.event_valid, 1);
        checkOutput("ovf_head", evIf.event_code, 8'h15);
        waitCycles(5);
        checkOutput("ovf_head_stable", evIf.event_code, 8'h15);
        evIf.event_ready = 1'b1;
        waitCycles(10);
        checkOutput("ovf_pop_count", gotQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (gotQ.size() > 0)
                checkOutput($sformatf("ovf_pop_%0d", i), gotQ.pop_front(), {ovCodes[i], 2'b00});
        end
        gotQ.delete();
        checkOutput("ovf_empty", evIf.event_valid, 0);
        checkOutput("ovf_sticky", overflow, 1);

        // Partial frame: start plus three data bits, then silence.
        errBefore = errPulses;
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        waitCycles(1500);
`ifdef PS2_TIMEOUT_EN
        checkOutput("timeout_err", errPulses - errBefore, 1);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkEvent("after_timeout", 8'h1C, 1'b0, 1'b0);
        errBefore = errPulses;
        sendBit(1'b0);
        sendBit(1'b1);
`else
        checkOutput("no_timeout_err", errPulses - errBefore, 0);
        checkOutput("no_timeout_event", gotQ.size(), 0);
`endif

        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(2);
        checkOutput("midrst_no_err", errPulses - errBefore, 0);
        checkOutput("midrst_overflow", overflow, 0);
        checkOutput("midrst_valid", evIf.event_valid, 0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkEvent("after_midrst", 8'h1C, 1'b0, 1'b0);
        checkOutput("midrst_final_err", errPulses - errBefore, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
